systolic_feeder: RTL and testbench

//  Operand source for the NxN systolic MAC array: holds matrix A (rows) and matrix B in local buffers and streams them as skewed x/y wavefronts.

---
 rtl/systolic_feeder.sv | 145 ++++++++++++++
 tb/tb_systolic_feeder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic MAC array: buffers A and B, streams skewed x/y wavefronts.
// Optional sticky err output enabled by defining FEEDER_ERR_EN.
module systolic_feeder #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned FLUSH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(N)-1:0]       wr_row,
  input  logic [N*D_W-1:0]           wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [N-1:0][D_W-1:0]      x,
  output logic [N-1:0][D_W-1:0]      y,
  output logic                       init
`ifdef FEEDER_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned CW        = $clog2(2 * N + FLUSH + 1);
  localparam int unsigned FeedLast  = 2 * N - 2;
  localparam int unsigned FlushLen  = N - 1 + FLUSH;

  logic [1:0]                         state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [N-1:0][N-1:0][D_W-1:0]       a_q, b_q;
  logic [N-1:0][D_W-1:0]              x_d, y_d;
  logic                               busy_d, done_d, init_d;
  logic                               wr_ok, start_ok;

  assign start_ok = (state_q == StIdle) && start && !wr_en;
  assign wr_ok    = (state_q == StIdle) && wr_en && (32'(wr_row) < N);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StFeed;
          cnt_d   = '0;
        end
      end
      StFeed: begin
        if (32'(cnt_q) == FeedLast) begin
          state_d = (FlushLen == 0) ? StDone : StFlush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFlush: begin
        if (32'(cnt_q) + 1 >= FlushLen) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they load on the edge entering each step.
  always_comb begin
    busy_d = (state_d == StFeed) || (state_d == StFlush);
    done_d = (state_d == StDone);
    init_d = (state_d == StFeed) && (cnt_d == '0);
    x_d    = '0;
    y_d    = '0;
    if (state_d == StFeed) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (32'(cnt_d) == i + k) begin
            x_d[i] = a_q[i][k];
            y_d[i] = b_q[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      init    <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      init    <= init_d;
      x       <= x_d;
      y       <= y_d;
      if (wr_ok) begin
        if (wr_sel) b_q[wr_row] <= wr_data;
        else        a_q[wr_row] <= wr_data;
      end
    end
  end

`ifdef FEEDER_ERR_EN
  logic err_ev;

  assign err_ev = (((state_q == StFeed) || (state_q == StFlush)) && (wr_en || start)) ||
                  ((state_q == StIdle) && start && wr_en) ||
                  (wr_en && (32'(wr_row) >= N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (err_ev) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=2, D_W=8, FLUSH=2): checks skewed streams
// against the operand matrices and the product an ideal array would accumulate.
module tb_systolic_feeder;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic             wr_sel;
  logic [0:0]       wr_row;
  logic [15:0]      wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [1:0][7:0]  x;
  logic [1:0][7:0]  y;
  logic             init;

  int errors = 0;
  int checks = 0;

  logic [7:0] ma [2][2];
  logic [7:0] mb [2][2];

  systolic_feeder #(.D_W(8), .N(2), .FLUSH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .x       (x),
    .y       (y),
    .init    (init)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic sel, input int row, input logic [7:0] e0,
                           input logic [7:0] e1, input logic with_start);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = row[0:0];
    wr_data = {e1, e0};
    start   = with_start;
    tick();
    wr_en   = 1'b0;
    start   = 1'b0;
    if (sel) begin mb[row][0] = e0; mb[row][1] = e1; end
    else     begin ma[row][0] = e0; ma[row][1] = e1; end
  endtask

  task automatic load(input logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11);
    write_row(1'b0, 0, a00, a01, 1'b0);
    write_row(1'b0, 1, a10, a11, 1'b0);
    write_row(1'b1, 0, b00, b01, 1'b0);
    write_row(1'b1, 1, b10, b11, 1'b0);
  endtask

  // Element that should be on row/column lane l at feed step c (0 outside the skew window).
  function automatic logic [7:0] want_x(int c, int l);
    if (c <= 2 && c >= l && c - l < 2) return ma[l][c-l];
    return 8'd0;
  endfunction

  function automatic logic [7:0] want_y(int c, int l);
    if (c <= 2 && c >= l && c - l < 2) return mb[c-l][l];
    return 8'd0;
  endfunction

  // One pass: 3 feed + 3 flush cycles, then done. Optionally pokes wr_en/start while busy.
  task automatic run_pass(input string name, input bit poke);
    int xs [6][2];
    int ys [6][2];
    int z, want;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " done"}, 32'(done), 32'd0);
      chk({name, " init"}, 32'(init), (c == 0) ? 32'd1 : 32'd0);
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("%s x%0d c%0d", name, l, c), 32'(x[l]), 32'(want_x(c, l)));
        chk($sformatf("%s y%0d c%0d", name, l, c), 32'(y[l]), 32'(want_y(c, l)));
        xs[c][l] = int'(x[l]);
        ys[c][l] = int'(y[l]);
      end
      wr_en   = poke && (c == 0);
      wr_sel  = 1'b0;
      wr_row  = 1'b0;
      wr_data = 16'($urandom);
      start   = poke && (c == 1);
    end
    wr_en = 1'b0;
    start = 1'b0;
    tick();
    chk({name, " done pulse"}, 32'(done), 32'd1);
    chk({name, " busy at done"}, 32'(busy), 32'd0);
    chk({name, " x at done"}, 32'(x), 32'd0);
    tick();
    chk({name, " done after"}, 32'(done), 32'd0);
    chk({name, " idle busy"}, 32'(busy), 32'd0);
    // PE(i,j) sees x[i] delayed j hops and y[j] delayed i hops.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        z = 0;
        want = 0;
        for (int t = 0; t < 8; t++)
          if (t - j >= 0 && t - i >= 0 && t - j < 6 && t - i < 6)
            z += xs[t-j][i] * ys[t-i][j];
        for (int k = 0; k < 2; k++) want += int'(ma[i][k]) * int'(mb[k][j]);
        chk($sformatf("%s z%0d%0d", name, i, j), 32'(z), 32'(want));
      end
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = 1'b0; wr_data = '0; start = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin ma[i][j] = 8'd0; mb[i][j] = 8'd0; end
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset init", 32'(init), 32'd0);
    chk("reset xy", 32'({x, y}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run_pass("basic", 1'b0);

    write_row(1'b1, 0, 8'd1, 8'd0, 1'b0);
    write_row(1'b1, 1, 8'd0, 8'd1, 1'b0);
    run_pass("ident", 1'b0);

    run_pass("poke", 1'b1);
    run_pass("after poke", 1'b0);

    write_row(1'b0, 1, 8'd9, 8'd11, 1'b1);
    chk("start+wr busy", 32'(busy), 32'd0);
    tick();
    chk("start+wr still idle", 32'(busy), 32'd0);
    run_pass("after start+wr", 1'b0);

    for (int r = 0; r < 3; r++) begin
      load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_pass($sformatf("rand%0d", r), 1'b0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst init", 32'(init), 32'd0);
    chk("midrst xy", 32'({x, y}), 32'd0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin ma[i][j] = 8'd0; mb[i][j] = 8'd0; end
    tick();
    chk("held rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post rst done", 32'(done), 32'd0);
    run_pass("zero bufs", 1'b0);
    load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_pass("restart", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
